seg7_scan_driver: RTL
=====================

# seg7_scan_driver

Parametrised, time-multiplexed hex seven-segment display driver. Decodes N_DIGITS 4-bit hex values into segment patterns and scans them onto a shared segment bus with one-hot digit enables. It has double-buffered loading, a ghosting guard interval, leading-zero suppression and per-digit decimal points. It sits between the datapath and the board display pins, and generalises the single-segment, single-digit combinational hex decode to a full scanned display.

## Interface
Parameters:
- N_DIGITS, 4, number of digits scanned; range 1..16.
- PRESCALE, 1000, clock cycles per digit slot; must be ≥ 2.
- GUARD, 2, dark cycles at the start of each slot; must satisfy 0 ≤ GUARD < PRESCALE.
- SEG_ACTIVE_LOW, 0, 1 inverts `seg` and `seg_dp`.
- DIG_ACTIVE_LOW, 0, 1 inverts `dig_en`.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `load`  in  1  one-cycle strobe that captures `data`, `dp` and `lz_en`.
- `data`  in  4*N_DIGITS  hex nibbles; nibble i feeds digit i (digit 0 is the least significant digit).
- `dp`  in  N_DIGITS  decimal-point request per digit.
- `lz_en`  in  1  leading-zero suppression enable.
- `seg`  out  7  segments, bit0=a … bit6=g.
- `seg_dp`  out  1  decimal-point segment.
- `dig_en`  out  N_DIGITS  one-hot digit enable.
- `frame_done`  out  1  one-cycle pulse when the scan wraps to digit 0.
- `pending`  out  1  shadow holds data that has not yet been committed.

## Operation
- Decode, with segments listed a–g. Inactive segments are low when SEG_ACTIVE_LOW=0.
  - 0 abcdef; 1 bc; 2 abdeg; 3 abcdg; 4 bcfg; 5 acdfg; 6 acdefg; 7 abc
  - 8 abcdefg; 9 abcdfg; A abcefg; b cdefg; C adef; d bcdeg; E adefg; F aefg
- Double buffer:
  - `load` writes `data`/`dp`/`lz_en` into the shadow register and sets `pending`.
  - At the frame-wrap edge (slot counter at PRESCALE-1 and digit index at N_DIGITS-1), shadow is copied to active and `pending` clears.
  - Several loads within one frame: the last one wins.
  - `load` on the wrap edge itself: the new data goes straight to both shadow and active, and `pending` ends at 0.
- Scan:
  - Prescaler `cnt` counts 0..PRESCALE-1.
  - Digit index `idx` advances when `cnt` wraps, and goes from N_DIGITS-1 back to 0.
- Guard: while `cnt < GUARD`, every `dig_en` bit is inactive. `seg` already carries the new digit during the guard.
- Leading-zero suppression, applied only when the active `lz_en`=1:
  - Digit i is blanked if it and every digit above it hold 0.
  - Digit 0 is never blanked.
  - A blanked digit drives all segments inactive, but `dig_en` still scans it.
  - `seg_dp` is driven from active `dp[idx]` even when the digit is blanked.
- Reset (asynchronous, effective immediately):
  - `cnt`, `idx`, shadow, active and `pending` clear to 0.
  - `seg` and `seg_dp` go to the inactive level; `dig_en` goes all inactive.
  - `frame_done` goes to 0.
  - Scanning restarts at digit 0 with `cnt`=0.

## Timing
- `seg`, `seg_dp`, `dig_en` and `frame_done` are registered. They reflect `cnt`/`idx`/active from the previous cycle, so latency is 1 cycle.
- Frame length is N_DIGITS*PRESCALE cycles. `frame_done` pulses once per frame, one cycle after the wrap edge.
- Latency from `load` to display is up to one frame plus 1 cycle. `pending` rises the cycle after `load`.
- In each slot, `dig_en[idx]` is active for PRESCALE-GUARD cycles.
- With GUARD=0 there is no dark interval.
- With N_DIGITS=1, `idx` is constant 0 and every slot wrap is also a frame wrap.
- Asserting `rst_n` mid-slot blanks the outputs asynchronously. The first slot after deassertion is a full PRESCALE cycles long.

## Test plan
- Reset: hold `rst_n`=0 with active-high parameters -> `seg`=0x00, `seg_dp`=0, `dig_en`=0, `frame_done`=0, `pending`=0. Then release -> digit 0 enabled at cycle GUARD+1.
- Decode sweep: N_DIGITS=1, PRESCALE=4, GUARD=0; load 0..F in turn -> `seg` = 0x3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F, 77, 7C, 39, 5E, 79, 71. Repeat with SEG_ACTIVE_LOW=1 -> bitwise inverse of each value.
- Scan/guard: N_DIGITS=4, PRESCALE=8, GUARD=2 -> `dig_en` runs 0001, 0010, 0100, 1000. Each slot is 2 cycles of 0000 followed by 6 active cycles. `frame_done` pulses every 32 cycles.
- Double buffer: active=0x0000; load 0x1234 while `idx`=1 -> digits keep showing 0 and `pending`=1 until the wrap. The next frame shows 4, 3, 2, 1 on digits 0..3 and `pending`=0. A second load landing exactly on the wrap edge is displayed in that same next frame.
- Leading-zero: `lz_en`=1, `data`=0x0050 -> digits 3 and 2 have `seg`=0x00 with `dig_en` still cycling; digit 1 shows 0x6D; digit 0 shows 0x3F. `data`=0x0000 -> only digit 0 is lit (0x3F). `dp`=4'b1000 -> `seg_dp`=1 during digit 3 even though digit 3 is blanked.
- Mid-operation reset: pull `rst_n` low during digit 2's active window -> outputs go inactive without waiting for `clk`. After release, the scan resumes at digit 0 with active data = 0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Scanned hex seven-segment driver: double-buffered load, guard interval, leading-zero blanking.
// Outputs registered (1-cycle latency); load is always accepted, and the last load before a frame wrap wins.
module seg7_scan_driver #(
  parameter int N_DIGITS       = 4,
  parameter int PRESCALE       = 1000,
  parameter int GUARD          = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic                  lz_en,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [N_DIGITS-1:0]   dig_en,
  output logic                  frame_done,
  output logic                  pending
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [CNT_W-1:0]    CNT_GUARD = CNT_W'(GUARD);
  localparam logic [6:0]          SEG_OFF   = {7{SEG_ACTIVE_LOW}};
  localparam logic [N_DIGITS-1:0] DIG_OFF   = {N_DIGITS{DIG_ACTIVE_LOW}};

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [4*N_DIGITS-1:0] shadow_data;
  logic [4*N_DIGITS-1:0] active_data;
  logic [N_DIGITS-1:0]   shadow_dp;
  logic [N_DIGITS-1:0]   active_dp;
  logic                  shadow_lz;
  logic                  active_lz;

  logic                  slot_end;
  logic                  frame_end;
  logic                  in_guard;
  logic [N_DIGITS-1:0]   blank;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [N_DIGITS-1:0]   cur_onehot;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  generate
    if (GUARD > 0) begin : g_guard
      assign in_guard = (cnt < CNT_GUARD);
    end else begin : g_no_guard
      assign in_guard = 1'b0;
    end
  endgenerate

  // A digit is blanked when it and everything above it is zero; digit 0 always shows.
  always_comb begin : lz_blank
    logic upper_zero;
    upper_zero = 1'b1;
    blank      = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (active_data[4*i +: 4] == 4'h0);
      blank[i]   = active_lz && upper_zero && (i != 0);
    end
  end

  always_comb begin
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    cur_onehot = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib       = active_data[4*i +: 4];
        cur_dp        = active_dp[i];
        cur_blank     = blank[i];
        cur_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      idx         <= '0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      shadow_lz   <= 1'b0;
      active_data <= '0;
      active_dp   <= '0;
      active_lz   <= 1'b0;
      pending     <= 1'b0;
      seg         <= SEG_OFF;
      seg_dp      <= SEG_ACTIVE_LOW;
      dig_en      <= DIG_OFF;
      frame_done  <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CNT_W'(1);
      if (slot_end) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end

      if (load) begin
        shadow_data <= data;
        shadow_dp   <= dp;
        shadow_lz   <= lz_en;
      end

      // A load coinciding with the wrap bypasses the shadow so it is not lost for a frame.
      if (frame_end) begin
        active_data <= load ? data  : shadow_data;
        active_dp   <= load ? dp    : shadow_dp;
        active_lz   <= load ? lz_en : shadow_lz;
        pending     <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end

      seg        <= (cur_blank ? 7'h00 : hex_to_seg(cur_nib)) ^ SEG_OFF;
      seg_dp     <= cur_dp ^ SEG_ACTIVE_LOW;
      dig_en     <= (in_guard ? '0 : cur_onehot) ^ DIG_OFF;
      frame_done <= frame_end;
    end
  end

endmodule
